// File: rtl/rst_ctrl_pkg.sv
// Register map and APB offset decode shared by the multi-core reset/boot controller.
package rst_ctrl_pkg;

   localparam int unsigned MAX_CORES = 8;

   localparam logic [7:0] OFS_HOLD      = 8'h00;
   localparam logic [7:0] OFS_SWRST     = 8'h04;
   localparam logic [7:0] OFS_STATUS    = 8'h08;
   localparam logic [7:0] OFS_BOOT_BASE = 8'h10;
   localparam logic [7:0] OFS_BOOT_END  = OFS_BOOT_BASE + 8'(4 * MAX_CORES);

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_HOLD,
      SEL_SWRST,
      SEL_STATUS,
      SEL_BOOT
   } reg_sel_e;

   typedef struct packed {
      reg_sel_e   sel;
      logic [2:0] idx;
   } reg_dec_t;

   // Boot slots beyond the instantiated core count decode as unmapped.
   function automatic reg_dec_t decode_ofs(input logic [7:0] ofs, input int unsigned num_cores);
      reg_dec_t dec;
      dec.sel = SEL_NONE;
      dec.idx = 3'((ofs - OFS_BOOT_BASE) >> 2);
      if (ofs == OFS_HOLD) begin
         dec.sel = SEL_HOLD;
      end else if (ofs == OFS_SWRST) begin
         dec.sel = SEL_SWRST;
      end else if (ofs == OFS_STATUS) begin
         dec.sel = SEL_STATUS;
      end else if ((ofs >= OFS_BOOT_BASE) && (ofs < OFS_BOOT_END) &&
                   (ofs[1:0] == 2'b00) && (32'(dec.idx) < num_cores)) begin
         dec.sel = SEL_BOOT;
      end
      return dec;
   endfunction

endpackage

// File: rtl/rst_ctrl_multi_rst_stretch.sv
// Per-core reset stretcher: reloadable saturating down-counter with a registered,
// maskable active-low core reset.
import rst_ctrl_pkg::*;

module rst_stretch #(
   parameter int unsigned RST_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic hold,
   output logic core_rst_no
);

   localparam int unsigned          CNT_W    = $clog2(RST_CYCLES + 1);
   localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'(RST_CYCLES);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             core_rst_no_q;
   logic             core_rst_no_d;

   // A reload always wins over the decrement of the same cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_INIT;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      core_rst_no_d = ~(hold | (cnt_q != '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= CNT_INIT;
         core_rst_no_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         core_rst_no_q <= core_rst_no_d;
      end
   end

   assign core_rst_no = core_rst_no_q;

endmodule

// File: rtl/rst_ctrl_multi.sv
// APB reset/boot controller: per-core boot address registers, a hold mask and
// software-triggered stretched resets driving each core's active-low reset.
import rst_ctrl_pkg::*;

module rst_ctrl_multi #(
   parameter int unsigned PADDR_SIZE        = 32,
   parameter int unsigned PDATA_SIZE        = 32,
   parameter int unsigned NUM_CORES         = 2,
   parameter logic [31:0] DEFAULT_BOOT_ADDR = 32'h1A00_0000,
   parameter int unsigned RST_CYCLES        = 16
) (
   input  logic                    PCLK,
   input  logic                    RESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic [PADDR_SIZE-1:0]   PADDR,
   input  logic [PDATA_SIZE-1:0]   PWDATA,
   input  logic                    PWRITE,
   output logic [PDATA_SIZE-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   output logic [32*NUM_CORES-1:0] rst_addr_o,
   output logic [NUM_CORES-1:0]    core_rst_no
);

   // Only core 0 is allowed to boot out of reset.
   localparam logic [NUM_CORES-1:0] HOLD_RST = ~NUM_CORES'(1);

   reg_dec_t             dec;
   logic                 access;
   logic                 err;
   logic                 wr_en;
   logic [31:0]          rdata;
   logic [31:0]          boot_sel;
   logic                 core_run_sel;
   logic [NUM_CORES-1:0] status;
   logic [NUM_CORES-1:0] hold_q;
   logic [NUM_CORES-1:0] hold_d;
   logic [NUM_CORES-1:0] swrst_load;
   logic [31:0]          boot_q [NUM_CORES];
   logic [31:0]          boot_d [NUM_CORES];
   logic                 unused_paddr;

   assign unused_paddr = ^PADDR;
   assign PREADY       = 1'b1;
   assign status       = ~core_rst_no;

   always_comb begin
      dec          = decode_ofs(PADDR[7:0], NUM_CORES);
      access       = PSEL & PENABLE;
      boot_sel     = '0;
      core_run_sel = 1'b0;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
         if (dec.idx == 3'(i)) begin
            boot_sel     = boot_q[i];
            core_run_sel = core_rst_no[i];
         end
      end

      rdata = '0;
      err   = 1'b0;
      case (dec.sel)
         SEL_HOLD:   rdata = 32'(hold_q);
         SEL_SWRST:  rdata = '0;
         SEL_STATUS: begin
            rdata = 32'(status);
            err   = PWRITE;
         end
         // A running core's boot address is locked.
         SEL_BOOT:   begin
            rdata = boot_sel;
            err   = PWRITE & core_run_sel;
         end
         default:    err = 1'b1;
      endcase

      wr_en   = access & PWRITE & ~err;
      PSLVERR = access & err;
      PRDATA  = (access & ~err) ? PDATA_SIZE'(rdata) : '0;
   end

   always_comb begin
      hold_d     = hold_q;
      swrst_load = '0;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
         boot_d[i] = boot_q[i];
      end
      if (wr_en) begin
         case (dec.sel)
            SEL_HOLD:  hold_d     = PWDATA[NUM_CORES-1:0];
            SEL_SWRST: swrst_load = PWDATA[NUM_CORES-1:0];
            SEL_BOOT:  begin
               for (int i = 0; i < int'(NUM_CORES); i++) begin
                  if (dec.idx == 3'(i)) begin
                     boot_d[i] = PWDATA[31:0];
                  end
               end
            end
            default:   ;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge RESETn) begin
      if (!RESETn) begin
         hold_q <= HOLD_RST;
         for (int i = 0; i < int'(NUM_CORES); i++) begin
            boot_q[i] <= DEFAULT_BOOT_ADDR;
         end
      end else begin
         hold_q <= hold_d;
         for (int i = 0; i < int'(NUM_CORES); i++) begin
            boot_q[i] <= boot_d[i];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < int'(NUM_CORES); gi++) begin : g_core
         assign rst_addr_o[32*gi +: 32] = boot_q[gi];

         rst_stretch #(
            .RST_CYCLES (RST_CYCLES)
         ) u_stretch (
            .clk         (PCLK),
            .rst_n       (RESETn),
            .load        (swrst_load[gi]),
            .hold        (hold_q[gi]),
            .core_rst_no (core_rst_no[gi])
         );
      end
   endgenerate

endmodule
